// File: rtl/alu_rr_sequencer.sv
// rtl/alu_rr_sequencer.sv - round-robin sequencer sharing one pipelined ALU between two requesters
module alu_rr_sequencer #(
  parameter int WIDTH   = 16,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic [15:0]      op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [2:0] LAT_INIT = 3'(ALU_LAT);

  state_t           state_q, state_d;
  logic             last_grant_q;
  logic [2:0]       cnt_q;
  logic [WIDTH-1:0] alu_a_q, alu_b_q, rsp_data_q;
  logic [2:0]       alu_op_q;
  logic             rsp_valid_q, rsp_id_q;
  logic [15:0]      op_count_q;

  logic             grant_valid, grant_id, accept;

  // Tie goes to whichever requester was not served last.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = ~last_grant_q;
    end else if (req0_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
  end

  assign accept     = (state_q == IDLE) && grant_valid && !rst;
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept && grant_id;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    if (cnt_q == 3'd0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= 3'd0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= 3'd0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      op_count_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            alu_op_q     <= grant_id ? req1_op : req0_op;
            alu_a_q      <= grant_id ? req1_a  : req0_a;
            alu_b_q      <= grant_id ? req1_b  : req0_b;
            rsp_id_q     <= grant_id;
            last_grant_q <= grant_id;
            cnt_q        <= LAT_INIT;
          end
        end
        EXEC: begin
          // The extra cycle at cnt==0 covers the ALU input-setup edge.
          if (cnt_q == 3'd0) begin
            rsp_data_q  <= alu_result;
            rsp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign op_count  = op_count_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// tb/tb_alu_rr_sequencer.sv - directed bench for alu_rr_sequencer at ALU_LAT=1 and ALU_LAT=3
module tb_alu_rr_sequencer;

  localparam logic [2:0] OP_AND = 3'd0, OP_NAND = 3'd1, OP_OR = 3'd2,
                         OP_XOR = 3'd3, OP_ADD = 3'd4, OP_SUB = 3'd5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_l1, req0_valid_l1, req0_ready_l1, req1_valid_l1, req1_ready_l1;
  logic [2:0]  req0_op_l1, req1_op_l1, alu_op_l1;
  logic [15:0] req0_a_l1, req0_b_l1, req1_a_l1, req1_b_l1, alu_a_l1, alu_b_l1, alu_result_l1;
  logic        rsp_valid_l1, rsp_ready_l1, rsp_id_l1, busy_l1;
  logic [15:0] rsp_data_l1, op_count_l1;

  logic        rst_l3, req0_valid_l3, req0_ready_l3, req1_valid_l3, req1_ready_l3;
  logic [2:0]  req0_op_l3, req1_op_l3, alu_op_l3;
  logic [15:0] req0_a_l3, req0_b_l3, req1_a_l3, req1_b_l3, alu_a_l3, alu_b_l3, alu_result_l3;
  logic        rsp_valid_l3, rsp_ready_l3, rsp_id_l3, busy_l3;
  logic [15:0] rsp_data_l3, op_count_l3;

  alu_rr_sequencer #(.WIDTH(16), .ALU_LAT(1)) u_l1 (
    .clk(clk), .rst(rst_l1),
    .req0_valid(req0_valid_l1), .req0_ready(req0_ready_l1), .req0_op(req0_op_l1),
    .req0_a(req0_a_l1), .req0_b(req0_b_l1),
    .req1_valid(req1_valid_l1), .req1_ready(req1_ready_l1), .req1_op(req1_op_l1),
    .req1_a(req1_a_l1), .req1_b(req1_b_l1),
    .alu_a(alu_a_l1), .alu_b(alu_b_l1), .alu_op(alu_op_l1), .alu_result(alu_result_l1),
    .rsp_valid(rsp_valid_l1), .rsp_ready(rsp_ready_l1), .rsp_id(rsp_id_l1),
    .rsp_data(rsp_data_l1), .busy(busy_l1), .op_count(op_count_l1)
  );

  alu_rr_sequencer #(.WIDTH(16), .ALU_LAT(3)) u_l3 (
    .clk(clk), .rst(rst_l3),
    .req0_valid(req0_valid_l3), .req0_ready(req0_ready_l3), .req0_op(req0_op_l3),
    .req0_a(req0_a_l3), .req0_b(req0_b_l3),
    .req1_valid(req1_valid_l3), .req1_ready(req1_ready_l3), .req1_op(req1_op_l3),
    .req1_a(req1_a_l3), .req1_b(req1_b_l3),
    .alu_a(alu_a_l3), .alu_b(alu_b_l3), .alu_op(alu_op_l3), .alu_result(alu_result_l3),
    .rsp_valid(rsp_valid_l3), .rsp_ready(rsp_ready_l3), .rsp_id(rsp_id_l3),
    .rsp_data(rsp_data_l3), .busy(busy_l3), .op_count(op_count_l3)
  );

  function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_NAND: return ~(a & b);
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      default: return 16'h0000;
    endcase
  endfunction

  // Reference ALUs: one register stage, and a three-stage pipeline.
  always @(posedge clk) alu_result_l1 <= alu_f(alu_op_l1, alu_a_l1, alu_b_l1);

  logic [15:0] pipe_l3 [3];
  always @(posedge clk) begin
    pipe_l3[0] <= alu_f(alu_op_l3, alu_a_l3, alu_b_l3);
    pipe_l3[1] <= pipe_l3[0];
    pipe_l3[2] <= pipe_l3[1];
  end
  assign alu_result_l3 = pipe_l3[2];

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  typedef struct {
    logic        id;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [7];

  // Issue one request on the ALU_LAT=1 instance; returns at the first rsp_valid-high cycle
  // (or after the handshake when rsp_ready is already high).
  task automatic run1(input logic id, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                      output logic [15:0] data, output logic rid, output int lat,
                      output logic [15:0] sa, output logic [15:0] sb, output logic [2:0] sop);
    int guard;
    if (!id) begin
      req0_op_l1 = op; req0_a_l1 = a; req0_b_l1 = b; req0_valid_l1 = 1'b1;
    end else begin
      req1_op_l1 = op; req1_a_l1 = a; req1_b_l1 = b; req1_valid_l1 = 1'b1;
    end
    guard = 0;
    @(negedge clk);
    while (!(id ? req1_ready_l1 : req0_ready_l1) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req0_valid_l1 = 1'b0;
    req1_valid_l1 = 1'b0;
    sa = alu_a_l1; sb = alu_b_l1; sop = alu_op_l1;
    lat = 0;
    while (!rsp_valid_l1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    data = rsp_data_l1;
    rid  = rsp_id_l1;
    if (rsp_ready_l1) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] d, sa, sb, exp_cnt;
    logic [2:0]  sop;
    logic        rid;
    int          lat, guard, nboth, bad;
    int          gid [$];
    int          gcyc [$];

    vecs[0] = '{1'b0, OP_AND,  16'hF0F0, 16'hFF00, 16'hF000};
    vecs[1] = '{1'b1, OP_NAND, 16'hF0F0, 16'hFF00, 16'h0FFF};
    vecs[2] = '{1'b0, OP_OR,   16'h1234, 16'h00FF, 16'h12FF};
    vecs[3] = '{1'b1, OP_XOR,  16'hAAAA, 16'hFFFF, 16'h5555};
    vecs[4] = '{1'b0, OP_ADD,  16'hFFFF, 16'h0001, 16'h0000};
    vecs[5] = '{1'b1, OP_SUB,  16'h0000, 16'h0001, 16'hFFFF};
    vecs[6] = '{1'b0, OP_ADD,  16'h1234, 16'h4321, 16'h5555};

    rst_l1 = 1'b1; rst_l3 = 1'b1;
    req0_valid_l1 = 0; req1_valid_l1 = 0; req0_op_l1 = 0; req1_op_l1 = 0;
    req0_a_l1 = 0; req0_b_l1 = 0; req1_a_l1 = 0; req1_b_l1 = 0; rsp_ready_l1 = 1'b1;
    req0_valid_l3 = 0; req1_valid_l3 = 0; req0_op_l3 = 0; req1_op_l3 = 0;
    req0_a_l3 = 0; req0_b_l3 = 0; req1_a_l3 = 0; req1_b_l3 = 0; rsp_ready_l3 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_l1 = 1'b0; rst_l3 = 1'b0;

    chk("rst_busy",      busy_l1,      0);
    chk("rst_rsp_valid", rsp_valid_l1, 0);
    chk("rst_rsp_id",    rsp_id_l1,    0);
    chk("rst_rsp_data",  rsp_data_l1,  0);
    chk("rst_alu_a",     alu_a_l1,     0);
    chk("rst_alu_b",     alu_b_l1,     0);
    chk("rst_alu_op",    alu_op_l1,    0);
    chk("rst_op_count",  op_count_l1,  0);

    exp_cnt = 16'd0;
    for (int i = 0; i < 7; i++) begin
      run1(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, d, rid, lat, sa, sb, sop);
      exp_cnt = exp_cnt + 16'd1;
      chk($sformatf("vec%0d_data", i),     d,           vecs[i].exp);
      chk($sformatf("vec%0d_id", i),       rid,         vecs[i].id);
      chk($sformatf("vec%0d_latency", i),  lat,         2);
      chk($sformatf("vec%0d_alu_a", i),    sa,          vecs[i].a);
      chk($sformatf("vec%0d_alu_b", i),    sb,          vecs[i].b);
      chk($sformatf("vec%0d_alu_op", i),   sop,         vecs[i].op);
      chk($sformatf("vec%0d_op_count", i), op_count_l1, exp_cnt);
    end
    chk("idle_alu_a_held", alu_a_l1, vecs[6].a);
    chk("idle_busy",       busy_l1,  0);

    // Backpressure: response held for five cycles with a competing request pending.
    rsp_ready_l1 = 1'b0;
    run1(1'b0, OP_NAND, 16'hF0F0, 16'hFF00, d, rid, lat, sa, sb, sop);
    chk("bp_data", d, 16'h0FFF);
    chk("bp_id",   rid, 0);
    req1_op_l1 = OP_OR; req1_a_l1 = 16'h0001; req1_b_l1 = 16'h0002; req1_valid_l1 = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (!rsp_valid_l1 || rsp_data_l1 !== 16'h0FFF || rsp_id_l1 !== 1'b0 ||
          req0_ready_l1 || req1_ready_l1 || !busy_l1 || op_count_l1 !== exp_cnt) bad++;
    end
    chk("bp_stable_cycles_bad", bad, 0);
    rsp_ready_l1 = 1'b1;
    @(posedge clk); #1;
    req1_valid_l1 = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    chk("bp_rsp_valid_cleared", rsp_valid_l1, 0);
    chk("bp_op_count",          op_count_l1,  exp_cnt);
    chk("bp_busy",              busy_l1,      0);

    // Reset with a request pending: ready must stay low during the reset cycle.
    rst_l1 = 1'b1;
    req0_op_l1 = OP_ADD; req0_a_l1 = 16'h0001; req0_b_l1 = 16'h0002; req0_valid_l1 = 1'b1;
    @(negedge clk);
    chk("rst_cycle_ready0", req0_ready_l1, 0);
    @(posedge clk); #1;
    rst_l1 = 1'b0;
    exp_cnt = 16'd0;
    chk("rst2_op_count", op_count_l1, 0);

    // Round robin with both requesters continuously valid.
    req1_op_l1 = OP_SUB; req1_a_l1 = 16'h0005; req1_b_l1 = 16'h0003; req1_valid_l1 = 1'b1;
    nboth = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (req0_ready_l1 && req1_ready_l1) nboth++;
      if (req0_ready_l1) begin gid.push_back(0); gcyc.push_back(c); end
      if (req1_ready_l1) begin gid.push_back(1); gcyc.push_back(c); end
      if (req0_ready_l1 || req1_ready_l1) exp_cnt = exp_cnt + 16'd1;
    end
    req0_valid_l1 = 1'b0;
    req1_valid_l1 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("rr_both_ready", nboth, 0);
    chk("rr_grant_count", gid.size(), 10);
    chk("rr_first_grant", gid.size() > 0 ? gid[0] : -1, 0);
    bad = 0;
    for (int k = 1; k < gid.size(); k++)
      if (gid[k] == gid[k-1] || gcyc[k] - gcyc[k-1] != 4) bad++;
    chk("rr_alternation_bad", bad, 0);
    chk("rr_op_count", op_count_l1, exp_cnt);

    // Wrap of the completion counter.
    @(negedge clk);
    force u_l1.op_count_q = 16'hFFFF;
    #1;
    release u_l1.op_count_q;
    @(posedge clk); #1;
    chk("wrap_preload", op_count_l1, 16'hFFFF);
    run1(1'b1, OP_OR, 16'h00F0, 16'h000F, d, rid, lat, sa, sb, sop);
    chk("wrap_data",     d,           16'h00FF);
    chk("wrap_op_count", op_count_l1, 16'h0000);

    // ALU_LAT=3: reset while an op from requester 0 is in EXEC with cnt=1.
    @(posedge clk); #1;
    req0_op_l3 = OP_XOR; req0_a_l3 = 16'hAAAA; req0_b_l3 = 16'h5555; req0_valid_l3 = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!req0_ready_l3 && guard < 20) begin @(negedge clk); guard++; end
    chk("l3_accept0", req0_ready_l3, 1);
    @(posedge clk); #1;
    req0_valid_l3 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("l3_exec_busy",      busy_l3,      1);
    chk("l3_exec_rsp_valid", rsp_valid_l3, 0);
    rst_l3 = 1'b1;
    @(posedge clk); #1;
    rst_l3 = 1'b0;
    chk("l3_rst_busy",      busy_l3,      0);
    chk("l3_rst_rsp_valid", rsp_valid_l3, 0);
    chk("l3_rst_alu_a",     alu_a_l3,     0);
    chk("l3_rst_alu_b",     alu_b_l3,     0);
    chk("l3_rst_alu_op",    alu_op_l3,    0);
    chk("l3_rst_op_count",  op_count_l3,  0);
    chk("l3_rst_rsp_id",    rsp_id_l3,    0);

    req0_op_l3 = OP_ADD; req0_a_l3 = 16'h1234; req0_b_l3 = 16'h4321; req0_valid_l3 = 1'b1;
    req1_op_l3 = OP_SUB; req1_a_l3 = 16'h1000; req1_b_l3 = 16'h0001; req1_valid_l3 = 1'b1;
    @(negedge clk);
    chk("l3_tie_ready0", req0_ready_l3, 1);
    chk("l3_tie_ready1", req1_ready_l3, 0);

    // Latency on ALU_LAT=3 with requester 1; its operands change right after accept.
    req0_valid_l3 = 1'b0;
    #1;
    chk("l3_ready1_alone", req1_ready_l3, 1);
    @(posedge clk); #1;
    req1_valid_l3 = 1'b0;
    req1_a_l3 = 16'hFFFF; req1_b_l3 = 16'hFFFF; req1_op_l3 = OP_AND;
    chk("l3_alu_a", alu_a_l3, 16'h1000);
    chk("l3_alu_b", alu_b_l3, 16'h0001);
    chk("l3_alu_op", alu_op_l3, OP_SUB);
    lat = 0;
    while (!rsp_valid_l3 && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("l3_latency",  lat,         4);
    chk("l3_rsp_data", rsp_data_l3, 16'h0FFF);
    chk("l3_rsp_id",   rsp_id_l3,   1);
    chk("l3_alu_a_held", alu_a_l3,  16'h1000);
    @(posedge clk); #1;
    chk("l3_op_count", op_count_l3, 1);
    chk("l3_done_busy", busy_l3,    0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
